// File: rtl/game_round_controller.sv
// ---------------------------------------------------------------------------
// game_round_controller
//   Gates NUM_PLAYERS player inputs and sequences a game of NUM_ROUNDS timed
//   rounds: WAIT -> RECONFIG -> PREGAME -> PLAY -> INTERMISSION/GAMEOVER.
//   Also raises logout / password-reset requests to the authentication side.
//
//   Optional feature macro: GAME_PAUSE_EN
//     defined   : start press in PLAY pauses (PAUSED), start again resumes.
//     undefined : start in PLAY is ignored, PAUSED recovers to WAIT.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   enable              authentication complete (level)
//   start_btn, logout_btn, preset_btn   buttons, rising-edge detected
//   player_in/out       raw / gated player controls (out idles at IDLE_MASK)
//   time_out            countdown expired
//   timer_reconfig      one-cycle load pulse, timer_load_value = ROUND_TIME
//   timer_enable        countdown running
//   score_enable        score display select
//   logout_s, pass_reset  requests to authentication
//   round_idx           current round (0-based)
//   state_o             state encoding for debug
// ---------------------------------------------------------------------------
module game_round_controller #(
  parameter int                     NUM_PLAYERS = 2,
  parameter logic [NUM_PLAYERS-1:0] IDLE_MASK   = 2'b10,
  parameter int                     NUM_ROUNDS  = 1,
  parameter int                     ROUND_TIME  = 99,
  parameter int                     TIMER_W     = 8,
  parameter int                     WAIT_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   start_btn,
  input  logic                   logout_btn,
  input  logic                   preset_btn,
  input  logic [NUM_PLAYERS-1:0] player_in,
  output logic [NUM_PLAYERS-1:0] player_out,
  input  logic                   time_out,
  output logic                   timer_reconfig,
  output logic [TIMER_W-1:0]     timer_load_value,
  output logic                   timer_enable,
  output logic                   score_enable,
  output logic                   logout_s,
  output logic                   pass_reset,
  output logic [3:0]             round_idx,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    S_WAIT     = 3'd0,
    S_RECONFIG = 3'd1,
    S_PREGAME  = 3'd2,
    S_PLAY     = 3'd3,
    S_INTER    = 3'd4,
    S_GAMEOVER = 3'd5,
    S_PAUSED   = 3'd6
  } state_t;

  localparam logic [7:0] CNT_MAX    = 8'(WAIT_CYCLES - 1);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  state_t                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [2:0]               hist_q, hist_d;   // {start, logout, preset}
  logic [NUM_PLAYERS-1:0]   pout_q, pout_d;
  logic                     recfg_q, recfg_d;
  logic                     ten_q, ten_d;
  logic                     score_q, score_d;
  logic                     logout_q, logout_d;
  logic                     prst_q, prst_d;
  logic [3:0]               round_q, round_d;

  logic start_p, logout_p, preset_p;
  logic enter_wait;

  assign start_p  = start_btn  & ~hist_q[2];
  assign logout_p = logout_btn & ~hist_q[1];
  assign preset_p = preset_btn & ~hist_q[0];

  // Outputs are loaded on the transition into a state, so they are valid
  // for the whole time the state register shows that state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hist_d     = {start_btn, logout_btn, preset_btn};
    pout_d     = pout_q;
    recfg_d    = recfg_q;
    ten_d      = ten_q;
    score_d    = score_q;
    logout_d   = logout_q;
    prst_d     = prst_q;
    round_d    = round_q;
    enter_wait = 1'b0;

    case (state_q)
      S_WAIT: begin
        pout_d = IDLE_MASK;
        if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          // Requests held until here give authentication time to drop enable.
          logout_d = 1'b0;
          prst_d   = 1'b0;
          if (enable) begin
            state_d = S_RECONFIG;
            recfg_d = 1'b1;
            score_d = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      S_RECONFIG: begin
        recfg_d = 1'b0;
        pout_d  = IDLE_MASK;
        state_d = S_PREGAME;
      end
      S_PREGAME: begin
        if (logout_p) begin
          logout_d   = 1'b1;
          enter_wait = 1'b1;
        end else if (preset_p) begin
          prst_d     = 1'b1;
          enter_wait = 1'b1;
        end else if (start_p) begin
          ten_d   = 1'b1;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        pout_d = player_in;
        if (time_out) begin
          pout_d  = IDLE_MASK;
          ten_d   = 1'b0;
          score_d = 1'b1;
          state_d = (round_q < LAST_ROUND) ? S_INTER : S_GAMEOVER;
        end
`ifdef GAME_PAUSE_EN
        else if (start_p) begin
          pout_d  = IDLE_MASK;
          ten_d   = 1'b0;
          state_d = S_PAUSED;
        end
`endif
      end
      S_INTER, S_GAMEOVER: begin
        if (logout_p) begin
          logout_d   = 1'b1;
          enter_wait = 1'b1;
        end else if (preset_p) begin
          prst_d     = 1'b1;
          enter_wait = 1'b1;
        end else if (start_p) begin
          if (state_q == S_INTER) begin
            round_d = round_q + 4'd1;
            recfg_d = 1'b1;
            score_d = 1'b0;
            state_d = S_RECONFIG;
          end else begin
            enter_wait = 1'b1;
          end
        end
      end
`ifdef GAME_PAUSE_EN
      S_PAUSED: begin
        if (logout_p) begin
          logout_d   = 1'b1;
          enter_wait = 1'b1;
        end else if (start_p) begin
          ten_d   = 1'b1;
          state_d = S_PLAY;
        end
      end
`endif
      default: begin
        // Illegal (or disabled PAUSED) encoding: recover with reset values.
        state_d  = S_WAIT;
        cnt_d    = '0;
        hist_d   = '0;
        pout_d   = IDLE_MASK;
        recfg_d  = 1'b0;
        ten_d    = 1'b0;
        score_d  = 1'b0;
        logout_d = 1'b0;
        prst_d   = 1'b0;
        round_d  = '0;
      end
    endcase

    // Any return to WAIT starts a fresh session.
    if (enter_wait) begin
      state_d = S_WAIT;
      pout_d  = IDLE_MASK;
      cnt_d   = '0;
      round_d = '0;
      ten_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_WAIT;
      cnt_q    <= '0;
      hist_q   <= '0;
      pout_q   <= IDLE_MASK;
      recfg_q  <= 1'b0;
      ten_q    <= 1'b0;
      score_q  <= 1'b0;
      logout_q <= 1'b0;
      prst_q   <= 1'b0;
      round_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hist_q   <= hist_d;
      pout_q   <= pout_d;
      recfg_q  <= recfg_d;
      ten_q    <= ten_d;
      score_q  <= score_d;
      logout_q <= logout_d;
      prst_q   <= prst_d;
      round_q  <= round_d;
    end
  end

  assign player_out       = pout_q;
  assign timer_reconfig   = recfg_q;
  assign timer_load_value = TIMER_W'(ROUND_TIME);
  assign timer_enable     = ten_q;
  assign score_enable     = score_q;
  assign logout_s         = logout_q;
  assign pass_reset       = prst_q;
  assign round_idx        = round_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_game_round_controller.sv
module tb_game_round_controller;

  logic       clk = 1'b0;
  logic       rst, enable, start_btn, logout_btn, preset_btn, time_out;
  logic [1:0] player_in, player_out;
  logic       timer_reconfig, timer_enable, score_enable, logout_s, pass_reset;
  logic [7:0] timer_load_value;
  logic [3:0] round_idx;
  logic [2:0] state_o;

  game_round_controller #(
    .NUM_PLAYERS(2), .IDLE_MASK(2'b10), .NUM_ROUNDS(3),
    .ROUND_TIME(99), .TIMER_W(8), .WAIT_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .start_btn(start_btn),
    .logout_btn(logout_btn), .preset_btn(preset_btn),
    .player_in(player_in), .player_out(player_out), .time_out(time_out),
    .timer_reconfig(timer_reconfig), .timer_load_value(timer_load_value),
    .timer_enable(timer_enable), .score_enable(score_enable),
    .logout_s(logout_s), .pass_reset(pass_reset),
    .round_idx(round_idx), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef enum {F_STATE, F_POUT, F_RECFG, F_TEN, F_SCORE, F_LOGOUT, F_PRST,
                F_ROUND, F_LOAD} fld_t;
  typedef struct {
    int    cyc;
    fld_t  f;
    int    exp;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(fld_t f);
    case (f)
      F_STATE:  return int'(state_o);
      F_POUT:   return int'(player_out);
      F_RECFG:  return int'(timer_reconfig);
      F_TEN:    return int'(timer_enable);
      F_SCORE:  return int'(score_enable);
      F_LOGOUT: return int'(logout_s);
      F_PRST:   return int'(pass_reset);
      F_ROUND:  return int'(round_idx);
      default:  return int'(timer_load_value);
    endcase
  endfunction

  // Monitor: compares every queued expectation at the negedge of its cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      int   a;
      e = sb.pop_front();
      a = actual(e.f);
      checks++;
      if (a !== e.exp) begin
        errors++;
        $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.name, cyc, a, e.exp);
      end
    end
  end

  task automatic chk(fld_t f, int e, string n);
    exp_t x;
    x.cyc = cyc; x.f = f; x.exp = e; x.name = n;
    sb.push_back(x);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; start_btn = 1'b0; logout_btn = 1'b0;
    preset_btn = 1'b0; time_out = 1'b0; player_in = 2'b01;
    step(2);
    rst = 1'b0; enable = 1'b1;
    chk(F_STATE, 0, "rst_state");   chk(F_POUT, 2, "rst_pout");
    chk(F_RECFG, 0, "rst_recfg");   chk(F_TEN, 0, "rst_ten");
    chk(F_SCORE, 0, "rst_score");   chk(F_LOGOUT, 0, "rst_logout");
    chk(F_PRST, 0, "rst_prst");     chk(F_ROUND, 0, "rst_round");
    chk(F_LOAD, 99, "load_value");

    // enable only acted on once the wait counter saturates
    step(1); chk(F_STATE, 0, "wait_c1");
    step(1); chk(F_STATE, 0, "wait_c2");
    step(1); chk(F_STATE, 1, "reconfig"); chk(F_RECFG, 1, "recfg_pulse");
    step(1); chk(F_STATE, 2, "pregame");  chk(F_RECFG, 0, "recfg_one_cycle");
    chk(F_POUT, 2, "pregame_idle");

    // start held 20 cycles: one transition, player_out tracks with 1 cycle lag
    start_btn = 1'b1;
    step(1); chk(F_STATE, 3, "play"); chk(F_TEN, 1, "play_ten");
    chk(F_POUT, 2, "play_lag");
    step(1); chk(F_POUT, 1, "play_track01");
    player_in = 2'b00;
    step(1); chk(F_POUT, 0, "play_track00");
    step(17); chk(F_STATE, 3, "held_start_once");
    start_btn = 1'b0;

    // round 0 ends -> INTERMISSION
    time_out = 1'b1;
    step(1); chk(F_STATE, 4, "inter1"); chk(F_SCORE, 1, "inter1_score");
    chk(F_TEN, 0, "inter1_ten"); chk(F_POUT, 2, "inter1_idle");
    chk(F_ROUND, 0, "inter1_round");
    time_out = 1'b0; start_btn = 1'b1;
    step(1); chk(F_STATE, 1, "recfg_r1"); chk(F_ROUND, 1, "round1");
    chk(F_SCORE, 0, "recfg_r1_score");
    start_btn = 1'b0;
    step(1); chk(F_STATE, 2, "pregame_r1");
    start_btn = 1'b1;
    step(1); chk(F_STATE, 3, "play_r1");
    start_btn = 1'b0; time_out = 1'b1;
    step(1); chk(F_STATE, 4, "inter2"); chk(F_ROUND, 1, "inter2_round");
    time_out = 1'b0; start_btn = 1'b1;
    step(1); chk(F_STATE, 1, "recfg_r2"); chk(F_ROUND, 2, "round2");
    start_btn = 1'b0;
    step(1); chk(F_STATE, 2, "pregame_r2");
    start_btn = 1'b1;
    step(1); chk(F_STATE, 3, "play_r2");
    start_btn = 1'b0;
    step(1);
    // time_out wins over a simultaneous start press
    time_out = 1'b1; start_btn = 1'b1;
    step(1); chk(F_STATE, 5, "gameover"); chk(F_SCORE, 1, "gameover_score");
    chk(F_ROUND, 2, "gameover_round"); chk(F_TEN, 0, "gameover_ten");
    time_out = 1'b0; start_btn = 1'b0;

    // logout and preset together: logout wins
    enable = 1'b0; logout_btn = 1'b1; preset_btn = 1'b1;
    step(1); chk(F_STATE, 0, "logout_wait"); chk(F_LOGOUT, 1, "logout_set");
    chk(F_PRST, 0, "logout_over_preset"); chk(F_ROUND, 0, "logout_round_clr");
    logout_btn = 1'b0; preset_btn = 1'b0;
    step(1); chk(F_LOGOUT, 1, "logout_hold1");
    step(1); chk(F_LOGOUT, 1, "logout_hold2");
    step(1); chk(F_LOGOUT, 0, "logout_clear"); chk(F_STATE, 0, "still_wait");

    // preset from PREGAME
    enable = 1'b1;
    step(1); chk(F_STATE, 1, "reconfig2");
    step(1); chk(F_STATE, 2, "pregame2");
    preset_btn = 1'b1;
    step(1); chk(F_STATE, 0, "preset_wait"); chk(F_PRST, 1, "preset_set");
    chk(F_LOGOUT, 0, "preset_no_logout");
    preset_btn = 1'b0;
    step(3); chk(F_STATE, 1, "reconfig3"); chk(F_PRST, 0, "preset_clear");
    step(1); chk(F_STATE, 2, "pregame3");
    start_btn = 1'b1;
    step(1); chk(F_STATE, 3, "play3");
    start_btn = 1'b0;
    step(1);
`ifdef GAME_PAUSE_EN
    start_btn = 1'b1;
    step(1); chk(F_STATE, 6, "paused"); chk(F_TEN, 0, "paused_ten");
    chk(F_POUT, 2, "paused_idle");
    start_btn = 1'b0; time_out = 1'b1;
    step(1); chk(F_STATE, 6, "paused_ignores_timeout");
    time_out = 1'b0; start_btn = 1'b1;
    step(1); chk(F_STATE, 3, "resume"); chk(F_TEN, 1, "resume_ten");
    start_btn = 1'b0;
`endif
    // synchronous reset mid-game
    rst = 1'b1;
    step(1); chk(F_STATE, 0, "midrst_state"); chk(F_TEN, 0, "midrst_ten");
    chk(F_POUT, 2, "midrst_pout"); chk(F_ROUND, 0, "midrst_round");
    chk(F_SCORE, 0, "midrst_score");
    rst = 1'b0;

    step(2);
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_round_controller.md
Name: game_round_controller

Overview:
Parametrised successor to the two-player game controller. It sits behind the authentication half and gates N player inputs. It sequences one or more timed rounds: timer reconfigure, pre-start hold, play, intermission, game over. It also raises logout and password-reset requests back to the authentication half.

Parameters:
NUM_PLAYERS, 2, number of gated player input channels (1..8)
IDLE_MASK, 2'b10, idle/blocked level driven on each player_out bit (bit i = player i)
NUM_ROUNDS, 1, rounds per game (1..15)
ROUND_TIME, 99, value presented on timer_load_value for every round
TIMER_W, 8, width of timer_load_value
WAIT_CYCLES, 3, settle cycles in WAIT before enable is sampled (1..255)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
enable  input  1  level; authentication complete
start_btn  input  1  game start/continue button, active-high
logout_btn  input  1  logout request, active-high
preset_btn  input  1  password-reset request, active-high
player_in  input  NUM_PLAYERS  raw player controls
player_out  output  NUM_PLAYERS  gated player controls
time_out  input  1  countdown expired, active-high
timer_reconfig  output  1  one-cycle load pulse to timer
timer_load_value  output  TIMER_W  constant ROUND_TIME
timer_enable  output  1  countdown running
score_enable  output  1  score display select
logout_s  output  1  logout request to authentication
pass_reset  output  1  password-reset request to authentication
round_idx  output  4  current round, 0-based
state_o  output  3  current state encoding, for debug

Behaviour:
- All outputs registered. Reset values: state WAIT, player_out=IDLE_MASK, timer_reconfig=0, timer_enable=0, score_enable=0, logout_s=0, pass_reset=0, round_idx=0, wait counter=0, button history=0.
- Buttons (start_btn, logout_btn, preset_btn) are rising-edge detected internally with a one-register history. Only a 0->1 transition counts as a press. A held button fires once.
- Press priority within one cycle: logout > preset > start.
- State encoding: WAIT=0, RECONFIG=1, PREGAME=2, PLAY=3, INTERMISSION=4, GAMEOVER=5, PAUSED=6. Any other value recovers to WAIT with reset output values.
- WAIT:
  - Wait counter increments up to WAIT_CYCLES-1. enable is ignored until the counter saturates.
  - Once saturated: logout_s=0 and pass_reset=0. If enable=1, go to RECONFIG.
- RECONFIG (1 cycle):
  - timer_reconfig=1, score_enable=0, wait counter cleared.
  - Go to PREGAME.
- PREGAME:
  - timer_reconfig=0. player_out holds IDLE_MASK.
  - Start press: timer_enable=1, go to PLAY.
  - Logout press: logout_s=1, go to WAIT.
  - Preset press: pass_reset=1, go to WAIT.
- PLAY:
  - player_out=player_in, one-cycle registered latency.
  - time_out=1 moves the state on the next edge. time_out takes precedence over any press in the same cycle.
  - If round_idx < NUM_ROUNDS-1, go to INTERMISSION. Otherwise go to GAMEOVER.
  - Logout and preset presses are ignored in PLAY.
- INTERMISSION:
  - player_out=IDLE_MASK, timer_enable=0, score_enable=1.
  - Start press: round_idx+1, go to RECONFIG.
  - Logout and preset presses are handled as in PREGAME, and round_idx is cleared.
- GAMEOVER:
  - player_out=IDLE_MASK, timer_enable=0, score_enable=1.
  - Start press: round_idx=0, go to WAIT.
  - Logout and preset presses are handled as in PREGAME, and round_idx is cleared.
- Entry into WAIT from any state forces player_out=IDLE_MASK and clears the wait counter.
- logout_s and pass_reset stay high throughout WAIT until the counter saturates. This guarantees at least WAIT_CYCLES cycles for authentication to drop enable.
- rst asserted mid-game returns to reset values on the next edge, including round_idx and timer_enable.
- round_idx never exceeds NUM_ROUNDS-1. With NUM_ROUNDS=1, INTERMISSION is unreachable.

Optional Feature:
GAME_PAUSE_EN
- Defined:
  - Start press in PLAY goes to PAUSED: timer_enable=0, player_out=IDLE_MASK.
  - Start press in PAUSED returns to PLAY with timer_enable=1.
  - time_out is ignored while in PAUSED.
  - Logout press in PAUSED: logout_s=1, go to WAIT.
- Undefined:
  - Start press in PLAY is ignored.
  - PAUSED (6) is unreachable and recovers to WAIT.

Test Plan:
1. Reset then enable=1 -> enable is not acted on until the 3rd post-reset cycle; RECONFIG follows with timer_reconfig high for exactly one cycle; timer_load_value=99.
2. PREGAME with player_in=2'b01 -> player_out=2'b10; start press -> timer_enable=1; player_out tracks player_in one cycle later.
3. NUM_ROUNDS=3, time_out pulsed three times with start presses between -> round_idx sequence 0,1,2; INTERMISSION twice, then GAMEOVER with score_enable=1.
4. logout_btn and preset_btn rise in the same GAMEOVER cycle -> only logout_s=1; state WAIT; logout_s clears after WAIT_CYCLES once enable=0.
5. start_btn held high for 20 cycles in PREGAME -> exactly one transition to PLAY; no pause toggle (macro undefined).
6. GAME_PAUSE_EN defined: start press in PLAY -> PAUSED, timer_enable=0; time_out=1 ignored; second press -> PLAY, timer_enable=1; rst asserted -> all outputs return to reset values on the next edge.
